// File: rtl/bpsk_txd_param.sv
// bpsk_txd_param: BPSK transmitter built from a phase-accumulator NCO, a sine LUT and PRBS7 or external symbols
module bpsk_txd_param #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int SPS     = 20
) (
    input  logic                     clk_sig,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [PHASE_W-1:0]       fcw,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic signed [DATA_W-1:0] txd_sig,
    output logic                     txd_valid,
    output logic                     sym_strobe,
    output logic                     underrun
);
    localparam int  CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int  LUT_N = 1 << LUT_AW;
    localparam real AMP   = 2.0 ** (DATA_W - 1) - 1.0;
    localparam real PI    = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    function automatic logic signed [DATA_W-1:0] lut_val(input int k);
        real r;
        r = AMP * $sin(2.0 * PI * real'(k) / real'(LUT_N));
        return DATA_W'((r < 0.0) ? -$rtoi(0.5 - r) : $rtoi(r + 0.5));
    endfunction

    logic signed [DATA_W-1:0] lut [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = lut_val(k);
    end

    state_t                   state_q, state_d;
    logic [PHASE_W-1:0]       phase_q, phase_d, fcw_q, fcw_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [6:0]               prbs_q, prbs_d;
    logic                     sym_q, sym_d, blank_q, blank_d, underrun_q, underrun_d;
    logic                     active, last, fetch, prbs_bit, keep;
    logic signed [DATA_W-1:0] lut_q, txd_q;
    logic                     neg1_q, blank1_q, vld1_q, stb1_q, vld2_q, stb2_q;

    // Next state, symbol fetch and NCO advance; a fetch uses the newly latched fcw and bit immediately
    always_comb begin
        active     = state_q != IDLE;
        last       = cnt_q == CNT_W'(SPS - 1);
        fetch      = active && cnt_q == '0;
        prbs_bit   = prbs_q[6] ^ prbs_q[5];
        state_d    = !active ? (en ? RUN : IDLE) : (en ? RUN : (last ? IDLE : STOP));
        keep       = active && state_d != IDLE;
        fcw_d      = fetch ? fcw : fcw_q;
        sym_d      = fetch ? (mode ? bit_in : prbs_bit) : sym_q;
        blank_d    = fetch ? (mode && !bit_valid) : blank_q;
        prbs_d     = (fetch && !mode) ? {prbs_q[5:0], prbs_bit} : prbs_q;
        phase_d    = keep ? phase_q + fcw_d : '0;
        cnt_d      = (keep && !last) ? cnt_q + CNT_W'(1) : '0;
        underrun_d = (state_d == IDLE) ? 1'b0 : (underrun_q | (fetch && mode && !bit_valid));
    end

    assign bit_ready = fetch && mode;

    // Control, NCO and current-symbol registers
    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            fcw_q      <= '0;
            cnt_q      <= '0;
            prbs_q     <= 7'h7F;
            sym_q      <= 1'b0;
            blank_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            fcw_q      <= fcw_d;
            cnt_q      <= cnt_d;
            prbs_q     <= prbs_d;
            sym_q      <= sym_d;
            blank_q    <= blank_d;
            underrun_q <= underrun_d;
        end
    end

    // Two-stage sample pipeline: LUT lookup, then sign flip or blanking
    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) begin
            lut_q    <= '0;
            neg1_q   <= 1'b0;
            blank1_q <= 1'b0;
            vld1_q   <= 1'b0;
            stb1_q   <= 1'b0;
            txd_q    <= '0;
            vld2_q   <= 1'b0;
            stb2_q   <= 1'b0;
        end else begin
            lut_q    <= lut[phase_q[PHASE_W-1 -: LUT_AW]];
            neg1_q   <= sym_d;
            blank1_q <= blank_d;
            vld1_q   <= active;
            stb1_q   <= fetch;
            txd_q    <= (!vld1_q || blank1_q) ? '0 : (neg1_q ? -lut_q : lut_q);
            vld2_q   <= vld1_q;
            stb2_q   <= stb1_q;
        end
    end

    assign txd_sig    = txd_q;
    assign txd_valid  = vld2_q;
    assign sym_strobe = stb2_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_bpsk_txd_param.sv
// tb_bpsk_txd_param: scoreboard bench for bpsk_txd_param (SPS=20 main instance plus an SPS=1 instance)
module tb_bpsk_txd_param;
    localparam int SPS = 20;

    logic        clk_sig = 1'b0, rst_n = 1'b0, en = 1'b0, en1 = 1'b0;
    logic        mode = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
    logic [31:0] fcw = 32'h1000_0000;
    logic        bit_ready, txd_valid, sym_strobe, underrun;
    logic        bit_ready1, txd_valid1, sym_strobe1, underrun1;
    logic signed [15:0] txd_sig, txd_sig1;

    typedef struct packed {
        logic signed [15:0] s;
        logic               stb;
    } exp_t;

    exp_t q[$];
    int   got[$];
    int   nc = 0, nf = 0;
    int   base;
    exp_t e;

    int          m_st, m_cnt;
    logic [31:0] m_ph, m_f;
    logic [6:0]  m_prbs;
    bit          m_b, m_bl, m_ur;

    bpsk_txd_param #(.DATA_W(16), .PHASE_W(32), .LUT_AW(8), .SPS(SPS)) dut (
        .clk_sig(clk_sig), .rst_n(rst_n), .en(en), .mode(mode), .fcw(fcw),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .txd_sig(txd_sig), .txd_valid(txd_valid), .sym_strobe(sym_strobe), .underrun(underrun)
    );

    bpsk_txd_param #(.DATA_W(16), .PHASE_W(32), .LUT_AW(8), .SPS(1)) dut1 (
        .clk_sig(clk_sig), .rst_n(rst_n), .en(en1), .mode(mode), .fcw(fcw),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready1),
        .txd_sig(txd_sig1), .txd_valid(txd_valid1), .sym_strobe(sym_strobe1), .underrun(underrun1)
    );

    always #5 clk_sig = ~clk_sig;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
        nc++;
        assert (o === x) else begin
            nf++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(o), $signed(x));
        end
    endtask

    function automatic logic signed [15:0] ref_sin(input logic [31:0] ph);
        real a;
        a = 32767.0 * $sin(6.283185307179586 * real'(int'(ph[31:24])) / 256.0);
        return 16'((a < 0.0) ? -$rtoi(0.5 - a) : $rtoi(a + 0.5));
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_cnt = 0;
        m_ph = '0;
        m_f = '0;
        m_prbs = 7'h7F;
        m_b = 0;
        m_bl = 0;
        m_ur = 0;
    endtask

    task automatic model_step();
        bit   act, fetch;
        exp_t x;
        act = m_st != 0;
        fetch = act && m_cnt == 0;
        chk("bit_ready", bit_ready, fetch && mode);
        chk("underrun", underrun, m_ur);
        if (fetch) begin
            m_f = fcw;
            if (mode) begin
                m_b = bit_in;
                m_bl = !bit_valid;
                if (!bit_valid) m_ur = 1;
            end else begin
                m_b = m_prbs[6] ^ m_prbs[5];
                m_bl = 0;
                m_prbs = {m_prbs[5:0], m_b};
            end
        end
        if (act) begin
            x.s = m_bl ? 16'sd0 : (m_b ? -ref_sin(m_ph) : ref_sin(m_ph));
            x.stb = fetch;
            q.push_back(x);
        end
        if (!act) m_st = en ? 1 : 0;
        else m_st = en ? 1 : ((m_cnt == SPS - 1) ? 0 : 2);
        if (act && m_st != 0) begin
            m_ph = m_ph + m_f;
            m_cnt = (m_cnt == SPS - 1) ? 0 : m_cnt + 1;
        end else begin
            m_ph = '0;
            m_cnt = 0;
        end
        if (m_st == 0) m_ur = 0;
    endtask

    task automatic tick();
        #1;
        model_step();
        @(posedge clk_sig);
        #1;
    endtask

    task automatic sym(input logic b);
        bit_in = b;
        repeat (SPS) tick();
    endtask

    // Output side of the scoreboard: every live sample pops one expected entry
    always @(negedge clk_sig) if (rst_n) begin
        if (txd_valid) begin
            got.push_back(int'(txd_sig));
            chk("queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sample", txd_sig, e.s);
                chk("strobe", sym_strobe, e.stb);
            end
        end else begin
            chk("idle_sig", txd_sig, 0);
            chk("idle_strobe", sym_strobe, 0);
        end
    end

    initial begin
        model_reset();
        @(posedge clk_sig);
        #1;
        chk("rst_sig", txd_sig, 0);
        chk("rst_valid", txd_valid, 0);
        chk("rst_strobe", sym_strobe, 0);
        chk("rst_ready", bit_ready, 0);
        chk("rst_underrun", underrun, 0);
        rst_n = 1;
        // PRBS burst and start latency
        en = 1;
        tick();
        tick();
        chk("latency_pre", txd_valid, 0);
        tick();
        chk("latency", txd_valid, 1);
        repeat (150) tick();
        chk("s1_smp0", got[0], 0);
        chk("s1_smp1", got[1], 12539);
        chk("s1_smp2", got[2], 23170);
        chk("s1_smp3", got[3], 30273);
        chk("s1_smp4", got[4], 32767);
        chk("s7_first", got[120], 0);
        chk("s7_negated", got[124], -got[108]);
        // Async reset mid-burst, then replay of the same burst
        rst_n = 0;
        #1;
        chk("arst_sig", txd_sig, 0);
        chk("arst_valid", txd_valid, 0);
        chk("arst_strobe", sym_strobe, 0);
        chk("arst_ready", bit_ready, 0);
        model_reset();
        q.delete();
        base = got.size();
        #2;
        rst_n = 1;
        model_step();
        @(posedge clk_sig);
        #1;
        repeat (150) tick();
        for (int k = 0; k < 140; k++) chk("replay", got[base + k], got[k]);
        // Stop mid-symbol at cnt=7
        for (int i = 0; i < 2 * SPS && m_cnt != 7; i++) tick();
        chk("align_cnt7", m_cnt, 7);
        en = 0;
        repeat (SPS + 4) tick();
        chk("stop_whole_symbols", (got.size() - base) % SPS, 0);
        chk("stop_valid", txd_valid, 0);
        chk("stop_sig", txd_sig, 0);
        chk("stop_drained", q.size(), 0);
        // External stream 1,0,1 then underrun on a later symbol
        mode = 1;
        bit_valid = 1;
        bit_in = 1;
        en = 1;
        base = got.size();
        tick();
        sym(1);
        sym(0);
        sym(1);
        sym(0);
        bit_valid = 0;
        sym(0);
        bit_valid = 1;
        chk("underrun_set", underrun, 1);
        bit_in = 1;
        repeat (5) tick();
        en = 0;
        repeat (SPS + 4) tick();
        chk("underrun_clear", underrun, 0);
        chk("restart_phase0", got[base], 0);
        chk("ext_sym0_s4", got[base + 4], -32767);
        chk("ext_sym1_s16", got[base + 36], 32767);
        chk("ext_sym2_s4", got[base + 44], 32767);
        for (int k = 80; k < 100; k++) chk("blank_zero", got[base + k], 0);
        // fcw change at cnt=5 takes effect at the next symbol
        bit_in = 0;
        en = 1;
        base = got.size();
        tick();
        repeat (3 * SPS + 5) tick();
        fcw = 32'h2000_0000;
        repeat (15 + SPS) tick();
        en = 0;
        repeat (SPS + 4) tick();
        chk("fcw_old_75", got[base + 75], -30273);
        chk("fcw_old_79", got[base + 79], -12539);
        chk("fcw_new_80", got[base + 80], 0);
        chk("fcw_new_81", got[base + 81], 23170);
        chk("fcw_new_82", got[base + 82], 32767);
        chk("fcw_new_85", got[base + 85], -23170);
        // SPS=1 instance: fetch every cycle
        fcw = 32'h1000_0000;
        en1 = 1;
        tick();
        chk("sps1_ready_first", bit_ready1, 1);
        tick();
        tick();
        chk("sps1_smp0", txd_sig1, 0);
        tick();
        chk("sps1_smp1", txd_sig1, 12539);
        repeat (8) begin
            chk("sps1_valid", txd_valid1, 1);
            chk("sps1_strobe", sym_strobe1, 1);
            chk("sps1_ready", bit_ready1, 1);
            tick();
        end
        en1 = 0;
        repeat (4) tick();
        chk("sps1_idle_valid", txd_valid1, 0);
        chk("sps1_idle_sig", txd_sig1, 0);
        chk("sps1_idle_ready", bit_ready1, 0);
        chk("sps1_underrun", underrun1, 0);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
